// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, default Tnew width, exception codes
// and the per-cycle stage action used by the pipeline registers.
package pipe_pkg;

   localparam logic [31:0] NOP            = 32'h0000_0000;
   localparam int          TNEW_W_DEFAULT = 4;

   // ExcCode values carried on exc_in; zero means no exception.
   localparam logic [4:0] EXC_NONE    = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

   typedef enum logic [1:0] {
      ACT_LOAD,
      ACT_STALL,
      ACT_FLUSH
   } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg_tnew_sat_dec.sv
// Combinational saturating decrement of the Tnew hazard counter; never wraps
// below zero. TNEW_DEC is 0 or 1.
module tnew_sat_dec #(
   parameter int TNEW_W   = 4,
   parameter int TNEW_DEC = 1
) (
   input  logic [TNEW_W-1:0] tnew_i,
   output logic [TNEW_W-1:0] tnew_o
);

   localparam logic [TNEW_W-1:0] DEC_V = TNEW_W'(TNEW_DEC);

   // With a step of at most 1, only a zero input can underflow.
   assign tnew_o = (tnew_i == '0) ? '0 : tnew_i - DEC_V;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush and Tnew countdown.
// Define PIPE_STAGE_REG_EXC_EN to add the exception code / branch-delay fields.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int NWORD            = 4,
   parameter int TNEW_W           = TNEW_W_DEFAULT,
   parameter int TNEW_DEC         = 1,
   parameter bit KEEP_PC_ON_FLUSH = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  valid_in,
   input  logic [31:0]           instr_in,
   input  logic [31:0]           pc_in,
   input  logic [NWORD*32-1:0]   data_in,
   input  logic [TNEW_W-1:0]     tnew_in,
`ifdef PIPE_STAGE_REG_EXC_EN
   input  logic [4:0]            exc_in,
   input  logic [0:0]            bd_in,
   output logic [4:0]            exc_out,
   output logic [0:0]            bd_out,
`endif
   output logic                  valid_out,
   output logic [31:0]           instr_out,
   output logic [31:0]           pc_out,
   output logic [NWORD*32-1:0]   data_out,
   output logic [TNEW_W-1:0]     tnew_out
);

   logic                valid_q, valid_d;
   logic [31:0]         instr_q, instr_d;
   logic [31:0]         pc_q, pc_d;
   logic [NWORD*32-1:0] data_q, data_d;
   logic [TNEW_W-1:0]   tnew_q, tnew_d;
   logic [TNEW_W-1:0]   tnew_dec;
`ifdef PIPE_STAGE_REG_EXC_EN
   logic [4:0]          exc_q, exc_d;
   logic [0:0]          bd_q, bd_d;
`endif
   stage_act_e          act;

   tnew_sat_dec #(
      .TNEW_W   (TNEW_W),
      .TNEW_DEC (TNEW_DEC)
   ) u_tnew_dec (
      .tnew_i (tnew_in),
      .tnew_o (tnew_dec)
   );

   // Reset is handled in the flop block; flush outranks stall here.
   always_comb begin
      if (flush)      act = ACT_FLUSH;
      else if (stall) act = ACT_STALL;
      else            act = ACT_LOAD;
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no branch of the case can leave one unassigned and infer a latch.
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      data_d  = data_q;
      tnew_d  = tnew_q;
`ifdef PIPE_STAGE_REG_EXC_EN
      exc_d   = exc_q;
      bd_d    = bd_q;
`endif
      case (act)
         ACT_FLUSH: begin
            valid_d = 1'b0;
            instr_d = NOP;
            pc_d    = KEEP_PC_ON_FLUSH ? pc_in : 32'h0;
            data_d  = '0;
            tnew_d  = '0;
`ifdef PIPE_STAGE_REG_EXC_EN
            exc_d   = EXC_NONE;
            bd_d    = KEEP_PC_ON_FLUSH ? bd_in : 1'b0;
`endif
         end
         ACT_STALL: ;
         default: begin
            valid_d = valid_in;
            instr_d = instr_in;
            pc_d    = pc_in;
            data_d  = data_in;
            tnew_d  = valid_in ? tnew_dec : '0;
`ifdef PIPE_STAGE_REG_EXC_EN
            exc_d   = exc_in;
            bd_d    = bd_in;
            // A faulting instruction becomes a nop that produces no result.
            if (exc_in != EXC_NONE) begin
               instr_d = NOP;
               tnew_d  = '0;
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all flops update together from pre-edge values.
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
         data_q  <= '0;
         tnew_q  <= '0;
`ifdef PIPE_STAGE_REG_EXC_EN
         exc_q   <= '0;
         bd_q    <= '0;
`endif
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         data_q  <= data_d;
         tnew_q  <= tnew_d;
`ifdef PIPE_STAGE_REG_EXC_EN
         exc_q   <= exc_d;
         bd_q    <= bd_d;
`endif
      end
   end

   assign valid_out = valid_q;
   assign instr_out = instr_q;
   assign pc_out    = pc_q;
   assign data_out  = data_q;
   assign tnew_out  = tnew_q;
`ifdef PIPE_STAGE_REG_EXC_EN
   assign exc_out   = exc_q;
   assign bd_out    = bd_q;
`endif

endmodule
